// File: rtl/circular_dma_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : circular_dma_mc_if                                       |
// | Brief   : DataMover S2MM command and status stream bundle          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface circular_dma_mc_if #(
  parameter int C_ADDR_WIDTH = 32
);
  logic [C_ADDR_WIDTH+47:0] m_axis_s2mm_cmd_tdata;
  logic                     m_axis_s2mm_cmd_tvalid;
  logic                     m_axis_s2mm_cmd_tready;
  logic [7:0]               s_axis_s2mm_sts_tdata;
  logic                     s_axis_s2mm_sts_tvalid;
  logic                     s_axis_s2mm_sts_tready;

  modport master (
    output m_axis_s2mm_cmd_tdata,
    output m_axis_s2mm_cmd_tvalid,
    input  m_axis_s2mm_cmd_tready,
    input  s_axis_s2mm_sts_tdata,
    input  s_axis_s2mm_sts_tvalid,
    output s_axis_s2mm_sts_tready
  );

  modport slave (
    input  m_axis_s2mm_cmd_tdata,
    input  m_axis_s2mm_cmd_tvalid,
    output m_axis_s2mm_cmd_tready,
    output s_axis_s2mm_sts_tdata,
    output s_axis_s2mm_sts_tvalid,
    input  s_axis_s2mm_sts_tready
  );
endinterface
`default_nettype wire

// File: rtl/circular_dma_mc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : circular_dma_mc                                          |
// | Brief   : multi-channel circular-buffer S2MM DataMover commander;  |
// |           CIRCULAR_DMA_MC_STATS_EN adds per-channel byte counters  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module circular_dma_mc #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST  = 16,
  parameter int C_NUM_CH     = 2
) (
  input  wire                             clk,
  input  wire                             rst,
  input  wire                             enable,
  input  wire [C_NUM_CH*C_ADDR_WIDTH-1:0] cfg_base,
  input  wire [C_NUM_CH*32-1:0]           cfg_size,
  input  wire [31:0]                      cfg_irq_thr,
  input  wire [C_NUM_CH*32-1:0]           fifo_occupancy,
  input  wire [C_NUM_CH-1:0]              irq_ack,
  circular_dma_mc_if.master               dm,
  output logic [1:0]                      active_ch,
  output logic                            active_valid,
  output logic [C_NUM_CH*32-1:0]          wr_ptr,
  output logic [C_NUM_CH-1:0]             irq,
  output logic [C_NUM_CH-1:0]             err
`ifdef CIRCULAR_DMA_MC_STATS_EN
  ,
  output logic [C_NUM_CH*64-1:0]          stat_bytes
`endif
);

  localparam int BEAT_BYTES = C_AXIS_WIDTH / 8;
  localparam int LOG2B      = $clog2(BEAT_BYTES);
  localparam int CH_W       = (C_NUM_CH > 2) ? 2 : 1;
  localparam int CH_PAD     = 1 << CH_W;
  localparam int CMD_W      = C_ADDR_WIDTH + 48;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARB      = 2'd1,
    S_CMD      = 2'd2,
    S_WAIT_STS = 2'd3
  } state_t;

  state_t                  state_q;
  logic [C_ADDR_WIDTH-1:0] base_a    [CH_PAD];
  logic [31:0]             size_a    [CH_PAD];
  logic [31:0]             occ_a     [CH_PAD];
  logic [31:0]             room_a    [CH_PAD];
  logic [31:0]             wr_ptr_q  [CH_PAD];
  logic [31:0]             pending_q [CH_PAD];
  logic [CH_PAD-1:0]       err_q;
  logic [CH_PAD-1:0]       ack_a;
  logic [CH_W-1:0]         rr_q;
  logic [CH_W-1:0]         sel_q;
  logic [CH_W-1:0]         pick_d;
  logic [CH_W-1:0]         idx;
  logic                    found_d;
  logic [31:0]             beats_d;
  logic [31:0]             nbytes_d;
  logic [31:0]             nbytes_q;
  logic [CMD_W-1:0]        cmd_d;
  logic [CMD_W-1:0]        cmd_tdata_q;
  logic                    cmd_tvalid_q;
  logic                    sts_tready_q;
  logic                    active_valid_q;
  logic                    enable_q;
  logic [32:0]             pend_sum;
  logic [31:0]             ptr_sum;
  logic [31:0]             ptr_adv_d;
  logic [31:0]             pend_d;
  logic                    sts_fire;
  logic                    sts_ok;

  assign ack_a = CH_PAD'(irq_ack);

  // Channel slots above C_NUM_CH exist only to keep indices power-of-two; they never qualify.
  for (genvar k = 0; k < CH_PAD; k++) begin : g_ch
    if (k < C_NUM_CH) begin : g_real
      assign base_a[k]          = cfg_base[k*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      assign size_a[k]          = cfg_size[k*32 +: 32];
      assign occ_a[k]           = fifo_occupancy[k*32 +: 32];
      assign wr_ptr[k*32 +: 32] = wr_ptr_q[k];
      assign irq[k]             = (cfg_irq_thr != 32'd0) && (pending_q[k] >= cfg_irq_thr);
      assign err[k]             = err_q[k];
    end else begin : g_pad
      assign base_a[k] = '0;
      assign size_a[k] = '0;
      assign occ_a[k]  = '0;
    end
    assign room_a[k] = (size_a[k] - wr_ptr_q[k]) >> LOG2B;
  end

  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    idx     = '0;
    for (int i = 1; i <= CH_PAD; i++) begin
      idx = rr_q + CH_W'(i);
      if (!found_d && (occ_a[idx] != 32'd0) && !err_q[idx] && (room_a[idx] != 32'd0)) begin
        found_d = 1'b1;
        pick_d  = idx;
      end
    end
  end

  always_comb begin
    beats_d = occ_a[pick_d];
    if (beats_d > 32'(C_MAX_BURST)) beats_d = 32'(C_MAX_BURST);
    if (beats_d > room_a[pick_d])   beats_d = room_a[pick_d];
    nbytes_d = beats_d << LOG2B;
    cmd_d                                 = '0;
    cmd_d[22:0]                           = nbytes_d[22:0];
    cmd_d[23]                             = 1'b1;
    cmd_d[30]                             = 1'b1;
    cmd_d[C_ADDR_WIDTH+31:32]             = base_a[pick_d] + C_ADDR_WIDTH'(wr_ptr_q[pick_d]);
    cmd_d[C_ADDR_WIDTH+35:C_ADDR_WIDTH+32] = 4'(pick_d);
  end

  assign sts_fire  = (state_q == S_WAIT_STS) && sts_tready_q && dm.s_axis_s2mm_sts_tvalid;
  assign sts_ok    = dm.s_axis_s2mm_sts_tdata[7] && (dm.s_axis_s2mm_sts_tdata[6:4] == 3'b000);
  assign pend_sum  = {1'b0, pending_q[sel_q]} + {1'b0, nbytes_q};
  assign ptr_sum   = wr_ptr_q[sel_q] + nbytes_q;
  assign ptr_adv_d = (ptr_sum == size_a[sel_q]) ? 32'd0 : ptr_sum;
  // An acknowledge landing with the completion keeps just the new bytes.
  assign pend_d    = ack_a[sel_q] ? nbytes_q : (pend_sum[32] ? 32'hFFFF_FFFF : pend_sum[31:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cmd_tdata_q    <= '0;
      cmd_tvalid_q   <= 1'b0;
      sts_tready_q   <= 1'b0;
      active_valid_q <= 1'b0;
      sel_q          <= '0;
      rr_q           <= CH_W'(C_NUM_CH - 1);
      nbytes_q       <= '0;
      enable_q       <= 1'b0;
      err_q          <= '0;
      for (int k = 0; k < CH_PAD; k++) begin
        wr_ptr_q[k]  <= '0;
        pending_q[k] <= '0;
      end
    end else begin
      enable_q <= enable;
      for (int k = 0; k < CH_PAD; k++) begin
        if (ack_a[k]) pending_q[k] <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= S_ARB;
        end
        S_ARB: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (found_d) begin
            sel_q          <= pick_d;
            rr_q           <= pick_d;
            nbytes_q       <= nbytes_d;
            cmd_tdata_q    <= cmd_d;
            cmd_tvalid_q   <= 1'b1;
            active_valid_q <= 1'b1;
            state_q        <= S_CMD;
          end
        end
        S_CMD: begin
          if (dm.m_axis_s2mm_cmd_tready) begin
            cmd_tvalid_q <= 1'b0;
            sts_tready_q <= 1'b1;
            state_q      <= S_WAIT_STS;
          end
        end
        S_WAIT_STS: begin
          if (sts_fire) begin
            sts_tready_q   <= 1'b0;
            active_valid_q <= 1'b0;
            if (sts_ok) begin
              wr_ptr_q[sel_q]  <= ptr_adv_d;
              pending_q[sel_q] <= pend_d;
            end else begin
              err_q[sel_q] <= 1'b1;
            end
            state_q <= enable ? S_ARB : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A fresh run starts every buffer from its base with errors forgotten.
      if (enable && !enable_q) begin
        err_q <= '0;
        for (int k = 0; k < CH_PAD; k++) wr_ptr_q[k] <= '0;
      end
    end
  end

  assign dm.m_axis_s2mm_cmd_tdata  = cmd_tdata_q;
  assign dm.m_axis_s2mm_cmd_tvalid = cmd_tvalid_q;
  assign dm.s_axis_s2mm_sts_tready = sts_tready_q;
  assign active_valid              = active_valid_q;
  assign active_ch                 = 2'(sel_q);

`ifdef CIRCULAR_DMA_MC_STATS_EN
  logic [63:0] stat_q [CH_PAD];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH_PAD; k++) stat_q[k] <= '0;
    end else if (sts_fire && sts_ok) begin
      stat_q[sel_q] <= stat_q[sel_q] + 64'(nbytes_q);
    end
  end

  for (genvar k = 0; k < C_NUM_CH; k++) begin : g_stat
    assign stat_bytes[k*64 +: 64] = stat_q[k];
  end
`else
  // Statistics build option off: no byte counters exist.
`endif

endmodule
`default_nettype wire

// File: tb/tb_circular_dma_mc.sv
`default_nettype none
// Bench for circular_dma_mc: table of DataMover transactions plus enable,
// buffer-wrap and mid-transfer reset sequences.
module tb_circular_dma_mc;
  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] cfg_base;
  logic [63:0] cfg_size;
  logic [31:0] cfg_irq_thr;
  logic [31:0] occ0;
  logic [31:0] occ1;
  logic [1:0]  irq_ack;
  logic [1:0]  active_ch;
  logic        active_valid;
  logic [63:0] wr_ptr;
  logic [1:0]  irq;
  logic [1:0]  err;
`ifdef CIRCULAR_DMA_MC_STATS_EN
  logic [127:0] stat_bytes;
`endif

  int checks;
  int errors;

  circular_dma_mc_if #(.C_ADDR_WIDTH(AW)) dmi ();

  circular_dma_mc #(
    .C_ADDR_WIDTH(AW),
    .C_AXIS_WIDTH(64),
    .C_MAX_BURST (16),
    .C_NUM_CH    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cfg_base      (cfg_base),
    .cfg_size      (cfg_size),
    .cfg_irq_thr   (cfg_irq_thr),
    .fifo_occupancy({occ1, occ0}),
    .irq_ack       (irq_ack),
    .dm            (dmi),
    .active_ch     (active_ch),
    .active_valid  (active_valid),
    .wr_ptr        (wr_ptr),
    .irq           (irq),
    .err           (err)
`ifdef CIRCULAR_DMA_MC_STATS_EN
    ,
    .stat_bytes    (stat_bytes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int          btt;
    logic [31:0] saddr;
    bit          stall;
    bit          drop_en;
    logic [7:0]  sts;
    logic [1:0]  ack;
    logic [31:0] occ0_n;
    logic [31:0] occ1_n;
    logic [31:0] ptr_n;
    logic [1:0]  irq_n;
    logic [1:0]  err_n;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input int ch, input int btt, input logic [31:0] saddr,
                              input bit stall, input bit drop_en, input logic [7:0] sts,
                              input logic [1:0] ack, input logic [31:0] occ0_n,
                              input logic [31:0] occ1_n, input logic [31:0] ptr_n,
                              input logic [1:0] irq_n, input logic [1:0] err_n);
    vec_t v;
    v.ch = ch; v.btt = btt; v.saddr = saddr; v.stall = stall; v.drop_en = drop_en;
    v.sts = sts; v.ack = ack; v.occ0_n = occ0_n; v.occ1_n = occ1_n;
    v.ptr_n = ptr_n; v.irq_n = irq_n; v.err_n = err_n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_tvalid"}, 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd0);
    chk({tag, "_cmd_tdata_lo"}, dmi.m_axis_s2mm_cmd_tdata[63:0], 64'd0);
    chk({tag, "_cmd_tdata_hi"}, 64'(dmi.m_axis_s2mm_cmd_tdata[79:64]), 64'd0);
    chk({tag, "_sts_tready"}, 64'(dmi.s_axis_s2mm_sts_tready), 64'd0);
    chk({tag, "_active_valid"}, 64'(active_valid), 64'd0);
    chk({tag, "_active_ch"}, 64'(active_ch), 64'd0);
    chk({tag, "_wr_ptr"}, wr_ptr, 64'd0);
    chk({tag, "_irq"}, 64'(irq), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic cmd_phase(input vec_t v, output bit ok);
    int          t;
    logic [79:0] hold;
    t  = 0;
    ok = 1'b0;
    while (dmi.m_axis_s2mm_cmd_tvalid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_tvalid_seen", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd1);
    if (dmi.m_axis_s2mm_cmd_tvalid === 1'b1) begin
      hold = dmi.m_axis_s2mm_cmd_tdata;
      chk("cmd_tag", 64'(hold[67:64]), 64'(v.ch));
      chk("cmd_btt", 64'(hold[22:0]), 64'(v.btt));
      chk("cmd_flags", 64'(hold[31:23]), 64'h81);
      chk("cmd_saddr", 64'(hold[63:32]), 64'(v.saddr));
      chk("cmd_upper", 64'(hold[79:68]), 64'd0);
      chk("active_valid", 64'(active_valid), 64'd1);
      chk("active_ch", 64'(active_ch), 64'(v.ch));
      if (v.stall) begin
        @(negedge clk);
        chk("cmd_hold_valid", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd1);
        chk("cmd_hold_data", 64'(dmi.m_axis_s2mm_cmd_tdata == hold), 64'd1);
      end
      dmi.m_axis_s2mm_cmd_tready = 1'b1;
      @(negedge clk);
      dmi.m_axis_s2mm_cmd_tready = 1'b0;
      chk("sts_tready", 64'(dmi.s_axis_s2mm_sts_tready), 64'd1);
      chk("cmd_tvalid_drop", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd0);
      ok = 1'b1;
    end
  endtask

  task automatic xfer(input vec_t v);
    bit ok;
    cmd_phase(v, ok);
    if (ok) begin
      if (v.drop_en) enable = 1'b0;
      dmi.s_axis_s2mm_sts_tdata  = v.sts;
      dmi.s_axis_s2mm_sts_tvalid = 1'b1;
      irq_ack = v.ack;
      occ0    = v.occ0_n;
      occ1    = v.occ1_n;
      @(negedge clk);
      dmi.s_axis_s2mm_sts_tvalid = 1'b0;
      irq_ack = 2'b00;
      chk("wr_ptr", 64'(wr_ptr[v.ch*32 +: 32]), 64'(v.ptr_n));
      chk("irq", 64'(irq), 64'(v.irq_n));
      chk("err", 64'(err), 64'(v.err_n));
      chk("active_valid_after", 64'(active_valid), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    checks      = 0;
    errors      = 0;
    cfg_base    = {32'h2000_0000, 32'h1000_0000};
    cfg_size    = {32'd4096, 32'd4096};
    cfg_irq_thr = 32'd256;
    occ0        = 32'd40;
    occ1        = 32'd0;
    irq_ack     = 2'b00;
    dmi.m_axis_s2mm_cmd_tready = 1'b0;
    dmi.s_axis_s2mm_sts_tvalid = 1'b0;
    dmi.s_axis_s2mm_sts_tdata  = 8'h00;

    //            ch btt  saddr          stl drp sts    ack    occ0 occ1 ptr  irq    err
    tbl[0]  = mk(0, 128, 32'h1000_0000, 1, 0, 8'h80, 2'b00, 24, 0, 128, 2'b00, 2'b00);
    tbl[1]  = mk(0, 128, 32'h1000_0080, 0, 0, 8'h80, 2'b00, 8,  0, 256, 2'b01, 2'b00);
    tbl[2]  = mk(0, 64,  32'h1000_0100, 0, 0, 8'h80, 2'b00, 16, 0, 320, 2'b01, 2'b00);
    tbl[3]  = mk(0, 128, 32'h1000_0140, 0, 0, 8'h80, 2'b01, 8,  8, 448, 2'b00, 2'b00);
    tbl[4]  = mk(1, 64,  32'h2000_0000, 0, 0, 8'h80, 2'b00, 8,  8, 64,  2'b00, 2'b00);
    tbl[5]  = mk(0, 64,  32'h1000_01C0, 0, 0, 8'h80, 2'b00, 8,  8, 512, 2'b00, 2'b00);
    tbl[6]  = mk(1, 64,  32'h2000_0040, 0, 0, 8'h80, 2'b00, 8,  8, 128, 2'b00, 2'b00);
    tbl[7]  = mk(0, 64,  32'h1000_0200, 0, 0, 8'h80, 2'b00, 8,  8, 576, 2'b01, 2'b00);
    tbl[8]  = mk(1, 64,  32'h2000_0080, 1, 0, 8'h90, 2'b00, 8,  8, 128, 2'b01, 2'b10);
    tbl[9]  = mk(0, 64,  32'h1000_0240, 0, 0, 8'h80, 2'b00, 8,  8, 640, 2'b01, 2'b10);
    tbl[10] = mk(0, 64,  32'h1000_0280, 0, 0, 8'h80, 2'b00, 0,  0, 704, 2'b01, 2'b10);

    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_cmd", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd0);
    enable = 1'b1;

    for (int i = 0; i < 11; i++) xfer(tbl[i]);

    // Nothing eligible: engine parks, then disable/enable clears pointers and errors.
    repeat (3) @(negedge clk);
    chk("no_candidate_cmd", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_sticky", 64'(err), 64'h2);
    chk("wr_ptr0_held", 64'(wr_ptr[31:0]), 64'd704);
    enable = 1'b1;
    @(negedge clk);
    chk("rise_err_clear", 64'(err), 64'd0);
    chk("rise_ptr_clear", wr_ptr, 64'd0);

    // Fill channel 0 to 4064, then a 32-byte tail burst wraps the pointer.
    occ0 = 32'd16;
    for (int i = 0; i < 31; i++)
      xfer(mk(0, 128, 32'h1000_0000 + 32'(128 * i), 0, 0, 8'h80, 2'b00,
              (i == 30) ? 32'd12 : 32'd16, 0, 32'(128 * (i + 1)), 2'b01, 2'b00));
    xfer(mk(0, 96,  32'h1000_0F80, 0, 0, 8'h80, 2'b00, 16, 0, 4064, 2'b01, 2'b00));
    xfer(mk(0, 32,  32'h1000_0FE0, 0, 0, 8'h80, 2'b00, 16, 0, 0,    2'b01, 2'b00));
    xfer(mk(0, 128, 32'h1000_0000, 0, 1, 8'h80, 2'b00, 16, 0, 128,  2'b01, 2'b00));

    // Enable dropped during WAIT_STS: the status completes, then the engine idles.
    repeat (4) @(negedge clk);
    chk("disabled_no_cmd", 64'(dmi.m_axis_s2mm_cmd_tvalid), 64'd0);
    chk("disabled_inactive", 64'(active_valid), 64'd0);

    // Reset while waiting for a channel-1 status.
    occ0   = 32'd0;
    occ1   = 32'd8;
    enable = 1'b1;
    cmd_phase(mk(1, 64, 32'h2000_0000, 0, 0, 8'h80, 2'b00, 0, 8, 0, 2'b00, 2'b00), ok);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_wait");
    rst  = 1'b0;
    occ0 = 32'd8;
    // Round-robin pointer restarts at the last channel, so channel 0 goes first.
    cmd_phase(mk(0, 64, 32'h1000_0000, 0, 0, 8'h80, 2'b00, 8, 8, 0, 2'b00, 2'b00), ok);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
